s_wb_sched: RTL

Scalar write-back scheduler and register reservation tracker, sitting directly upstream of the scalar register file's single write port. At issue it reserves the destination S register and a write-back time slot at the functional unit's fixed latency. When the slot comes due it drives the register file write port with the functional-unit result. It stalls issue on source/destination reservation conflicts and on write-port slot collisions, as the Cray-1A issue logic requires.

---
 rtl/s_pkg.sv | 27 ++
 rtl/s_wb_sched_if.sv | 42 ++++
 rtl/s_wb_slot_chain.sv | 66 ++++++
 rtl/s_wb_sched.sv | 82 ++++++++
 4 files changed

// File: rtl/s_pkg.sv
// +---------------------------------------------------------------------------+
// | s_pkg : shared types and constants for the scalar write-back scheduler    |
// | Rev 1.0 - initial release                                                 |
// +---------------------------------------------------------------------------+
`default_nettype none

package s_pkg;

  localparam int S_WIDTH   = 64;
  localparam int S_NREG    = 8;
  localparam int S_LOGNREG = 3;
  localparam int S_LOGLAT  = 4;
  localparam int S_MAXLAT  = (1 << S_LOGLAT) - 1;

  typedef struct packed {
    logic                 valid;
    logic [S_LOGNREG-1:0] dest;
  } s_wb_slot_t;

  function automatic logic [S_NREG-1:0] s_onehot(input logic [S_LOGNREG-1:0] idx);
    s_onehot      = '0;
    s_onehot[idx] = 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/s_wb_sched_if.sv
// +---------------------------------------------------------------------------+
// | s_wb_sched_if : issue, result and register-file write port bundle         |
// | Rev 1.0 - initial release                                                 |
// +---------------------------------------------------------------------------+
`default_nettype none

interface s_wb_sched_if #(
  parameter int WIDTH = s_pkg::S_WIDTH
) ();

  logic                          i_issue_valid;
  logic [s_pkg::S_LOGNREG-1:0]   i_issue_dest;
  logic [s_pkg::S_LOGNREG-1:0]   i_issue_j;
  logic [s_pkg::S_LOGNREG-1:0]   i_issue_k;
  logic                          i_issue_juse;
  logic                          i_issue_kuse;
  logic [s_pkg::S_LOGLAT-1:0]    i_issue_lat;
  logic                          o_issue_ready;
  logic                          i_res_valid;
  logic [WIDTH-1:0]              i_res_data;
  logic                          o_wr_en;
  logic [s_pkg::S_LOGNREG-1:0]   o_wr_addr;
  logic [WIDTH-1:0]              o_wr_data;
  logic [s_pkg::S_NREG-1:0]      o_resv;
  logic                          o_busy;
  logic                          o_err;

  modport master (
    output i_issue_valid, i_issue_dest, i_issue_j, i_issue_k,
           i_issue_juse, i_issue_kuse, i_issue_lat, i_res_valid, i_res_data,
    input  o_issue_ready, o_wr_en, o_wr_addr, o_wr_data, o_resv, o_busy, o_err
  );

  modport slave (
    input  i_issue_valid, i_issue_dest, i_issue_j, i_issue_k,
           i_issue_juse, i_issue_kuse, i_issue_lat, i_res_valid, i_res_data,
    output o_issue_ready, o_wr_en, o_wr_addr, o_wr_data, o_resv, o_busy, o_err
  );

endinterface

`default_nettype wire

// File: rtl/s_wb_slot_chain.sv
// +---------------------------------------------------------------------------+
// | s_wb_slot_chain : shifting write-back slot array, head = slot due now     |
// | Rev 1.0 - initial release                                                 |
// +---------------------------------------------------------------------------+
`default_nettype none

module s_wb_slot_chain
  import s_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ins_en,
  input  logic [S_LOGLAT-1:0]  ins_lat,
  input  logic [S_LOGNREG-1:0] ins_dest,
  input  logic [S_LOGLAT-1:0]  q_lat,
  output logic                 q_occ,
  output s_wb_slot_t           head,
  output logic                 any_valid
);

  s_wb_slot_t slot_q [S_MAXLAT];
  s_wb_slot_t slot_d [S_MAXLAT];

  // Shift first, then insert; the insert index never collides with a shifted
  // entry because issue is held off while slot[L] is occupied.
  always_comb begin
    for (int p = 0; p < S_MAXLAT - 1; p++) begin
      slot_d[p] = slot_q[p+1];
    end
    slot_d[S_MAXLAT-1] = '0;
    if (ins_en) begin
      slot_d[ins_lat - 4'd1] = '{valid: 1'b1, dest: ins_dest};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int p = 0; p < S_MAXLAT; p++) begin
        slot_q[p] <= '0;
      end
    end else begin
      for (int p = 0; p < S_MAXLAT; p++) begin
        slot_q[p] <= slot_d[p];
      end
    end
  end

  always_comb begin
    q_occ = 1'b0;
    if (int'(q_lat) < S_MAXLAT) begin
      q_occ = slot_q[q_lat].valid;
    end
  end

  always_comb begin
    any_valid = 1'b0;
    for (int p = 0; p < S_MAXLAT; p++) begin
      any_valid = any_valid | slot_q[p].valid;
    end
  end

  assign head = slot_q[0];

endmodule

`default_nettype wire

// File: rtl/s_wb_sched.sv
// +---------------------------------------------------------------------------+
// | s_wb_sched : scalar write-back scheduler and S-register reservation unit  |
// | Option macro S_WB_BYPASS_EN : dependents may issue in the write cycle     |
// | Rev 1.0 - initial release                                                 |
// +---------------------------------------------------------------------------+
`default_nettype none

module s_wb_sched
  import s_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  s_wb_sched_if.slave  bus
);

  s_wb_slot_t        head;
  logic              occ;
  logic              any_valid;
  logic              issue_ready;
  logic              accept;
  logic [S_NREG-1:0] head_mask;
  logic [S_NREG-1:0] set_mask;
  logic [S_NREG-1:0] haz_resv;
  logic [S_NREG-1:0] resv_q, resv_d;
  logic              err_q, err_d;

  s_wb_slot_chain u_chain (
    .clk       (clk),
    .rst       (rst),
    .ins_en    (accept),
    .ins_lat   (bus.i_issue_lat),
    .ins_dest  (bus.i_issue_dest),
    .q_lat     (bus.i_issue_lat),
    .q_occ     (occ),
    .head      (head),
    .any_valid (any_valid)
  );

  assign head_mask = head.valid ? s_onehot(head.dest) : '0;

`ifdef S_WB_BYPASS_EN
  // The register file writes through, so the retiring register is readable now.
  assign haz_resv = resv_q & ~head_mask;
`else
  assign haz_resv = resv_q;
`endif

  always_comb begin
    issue_ready = rst
               && (bus.i_issue_lat != '0)
               && !haz_resv[bus.i_issue_dest]
               && !(bus.i_issue_juse && haz_resv[bus.i_issue_j])
               && !(bus.i_issue_kuse && haz_resv[bus.i_issue_k])
               && !occ;
    accept   = bus.i_issue_valid && issue_ready;
    set_mask = accept ? s_onehot(bus.i_issue_dest) : '0;
    // Clear applies before set so a same-edge reissue to the retiring dest holds.
    resv_d   = (resv_q & ~head_mask) | set_mask;
    err_d    = err_q | (head.valid != bus.i_res_valid);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      resv_q <= '0;
      err_q  <= 1'b0;
    end else begin
      resv_q <= resv_d;
      err_q  <= err_d;
    end
  end

  assign bus.o_issue_ready = issue_ready;
  assign bus.o_wr_en       = rst && head.valid && bus.i_res_valid;
  assign bus.o_wr_addr     = rst ? head.dest : '0;
  assign bus.o_wr_data     = bus.i_res_data;
  assign bus.o_resv        = resv_q;
  assign bus.o_busy        = any_valid;
  assign bus.o_err         = err_q;

endmodule

`default_nettype wire
